// File: rtl/ram_nway_pkg.sv
// Shared helpers and the response record for the N-channel arbitrated data RAM.
package ram_nway_pkg;

    // Upper bounds for the response record: at most 256 channels, 256-bit words.
    localparam int unsigned MaxChIdW = 8;
    localparam int unsigned MaxDataW = 256;

    function automatic int unsigned be_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned be_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    typedef struct packed {
        logic [MaxChIdW-1:0] ch_id;
        logic                err;
        logic [MaxDataW-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last granted requester.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    rot;
    logic            found;
    int              first;
    int              gidx;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        first = 0;
        // Rotate so bit 0 is the channel the search starts at.
        rot   = N'({req_i, req_i} >> ptr_q);
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                first = k;
            end
        end
        gidx = int'(ptr_q) + first;
        if (gidx >= int'(N)) begin
            gidx = gidx - int'(N);
        end
        if (found && !rst_i) begin
            for (int j = 0; j < N; j++) begin
                if (j == gidx) begin
                    gnt_o[j] = 1'b1;
                end
            end
            ptr_d = (gidx + 1 >= int'(N)) ? '0 : PtrW'(gidx + 1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_nway_data_arb.sv
// N-channel single-port data RAM behind a round-robin arbiter, 1-cycle response latency.
// Define RAM_NWAY_RDATA_REG_EN to add an output register (latency 2, full throughput).
module ram_nway_data_arb
    import ram_nway_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_CH-1:0]                req_i,
    input  logic [NUM_CH-1:0]                we_i,
    input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] be_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]     addr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     wdata_i,
    output logic [NUM_CH-1:0]                gnt_o,
    output logic [NUM_CH-1:0]                rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             err_o
);

    localparam int unsigned BeW    = be_width(DATA_WIDTH);
    localparam int unsigned BeLsb  = be_lsb(DATA_WIDTH);
    localparam int unsigned DepthW = $clog2(DEPTH);
    localparam int unsigned IdxW   = ADDR_WIDTH - BeLsb;

    logic [NUM_CH-1:0]     gnt;
    logic                  advance;
    logic                  sel_we;
    logic [BeW-1:0]        sel_be;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [MaxChIdW-1:0]   sel_ch;
    logic [IdxW-1:0]       word_idx;
    logic [DepthW-1:0]     mem_idx;
    logic                  range_err;
    logic                  access_wr;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    rsp_t s1_q, s1_d;
    logic s1_vld_q;
    rsp_t out_rsp;
    logic out_vld;
    logic unused_rsp;

    rr_arbiter #(
        .N(NUM_CH)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .advance_i (advance),
        .gnt_o     (gnt)
    );

    assign gnt_o   = gnt;
    assign advance = |gnt;

    always_comb begin
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_ch    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt[c]) begin
                sel_we    = we_i[c];
                sel_be    = be_i[c*BeW +: BeW];
                sel_addr  = addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata_i[c*DATA_WIDTH +: DATA_WIDTH];
                sel_ch    = MaxChIdW'(c);
            end
        end
    end

    assign word_idx = IdxW'(sel_addr >> BeLsb);

    // Out-of-range words only exist when the address space exceeds the array.
    generate
        if (IdxW > DepthW) begin : g_range_chk
            assign range_err = |word_idx[IdxW-1:DepthW];
            assign mem_idx   = word_idx[DepthW-1:0];
        end else begin : g_no_range_chk
            assign range_err = 1'b0;
            assign mem_idx   = DepthW'(word_idx);
        end
    endgenerate

    assign access_wr = advance & sel_we & ~range_err;

    always_ff @(posedge clk_i) begin
        if (access_wr) begin
            for (int b = 0; b < BeW; b++) begin
                if (sel_be[b]) begin
                    mem_q[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read data is captured only for in-range reads; writes leave it holding.
    always_comb begin
        s1_d = s1_q;
        if (advance) begin
            s1_d.ch_id = sel_ch;
            s1_d.err   = range_err;
            if (range_err) begin
                s1_d.rdata = '0;
            end else if (!sel_we) begin
                s1_d.rdata = MaxDataW'(mem_q[mem_idx]);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
        end else begin
            s1_vld_q <= advance;
            s1_q     <= s1_d;
        end
    end

`ifdef RAM_NWAY_RDATA_REG_EN
    rsp_t s2_q;
    logic s2_vld_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_vld_q <= 1'b0;
            s2_q     <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_q <= s1_q;
            end
        end
    end

    assign out_vld = s2_vld_q;
    assign out_rsp = s2_q;
`else
    assign out_vld = s1_vld_q;
    assign out_rsp = s1_q;
`endif

    always_comb begin
        rvalid_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (out_vld && (out_rsp.ch_id == MaxChIdW'(c))) begin
                rvalid_o[c] = 1'b1;
            end
        end
    end

    assign rdata_o    = out_rsp.rdata[DATA_WIDTH-1:0];
    assign err_o      = out_rsp.err;
    assign unused_rsp = ^out_rsp;

endmodule

// File: tb/tb_ram_nway_data_arb.sv
// Scoreboard bench for ram_nway_data_arb (2 channels, 32-bit words, 1024 deep).
module tb_ram_nway_data_arb;

`ifdef RAM_NWAY_RDATA_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic        chk;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        int          ch;
        logic        err;
        logic        chk;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we, gnt, rvalid;
    logic [7:0]  be;
    logic [63:0] addr, wdata;
    logic [31:0] rdata;
    logic        err;

    int   nchecks = 0;
    int   nerr    = 0;
    int   cyc     = 0;
    acc_t pend0[$];
    acc_t pend1[$];
    exp_t sb[$];
    logic [1:0] gseq[$];

    ram_nway_data_arb #(
        .NUM_CH     (2),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (1024)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .we_i     (we),
        .be_i     (be),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add(input int ch, input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] wd, input logic e, input logic c, input logic [31:0] d);
        acc_t x;
        x = '{we: w, be: b, addr: a, wdata: wd, err: e, chk: c, data: d};
        if (ch == 0) pend0.push_back(x);
        else         pend1.push_back(x);
    endtask

    task automatic drive();
        req = '0; we = '0; be = '0; addr = '0; wdata = '0;
        if (pend0.size() != 0) begin
            req[0] = 1'b1;        we[0] = pend0[0].we;         be[3:0] = pend0[0].be;
            addr[31:0] = pend0[0].addr; wdata[31:0] = pend0[0].wdata;
        end
        if (pend1.size() != 0) begin
            req[1] = 1'b1;        we[1] = pend1[0].we;         be[7:4] = pend1[0].be;
            addr[63:32] = pend1[0].addr; wdata[63:32] = pend1[0].wdata;
        end
    endtask

    // Issue all queued accesses; each grant pushes its expected response.
    task automatic run(input int budget);
        int   n = 0;
        acc_t a;
        while ((pend0.size() != 0 || pend1.size() != 0) && n < budget) begin
            drive();
            @(negedge clk);
            if (gseq.size() != 0) check("gnt_seq", gnt, gseq.pop_front());
            if (gnt == 2'b00) check("grant_missing", gnt, req);
            if (gnt[0]) begin
                a = pend0.pop_front();
                sb.push_back('{ch: 0, err: a.err, chk: a.chk, data: a.data, cyc: cyc});
            end
            if (gnt[1]) begin
                a = pend1.pop_front();
                sb.push_back('{ch: 1, err: a.err, chk: a.chk, data: a.data, cyc: cyc});
            end
            @(posedge clk); #1;
            n++;
        end
        check("run_timeout", 64'(pend0.size() + pend1.size()), 64'd0);
        pend0.delete();
        pend1.delete();
        drive();
        repeat (LAT + 1) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rvalid != 2'b00) begin
            if (sb.size() == 0) begin
                check("spurious_rvalid", rvalid, 2'b00);
            end else begin
                e = sb.pop_front();
                check("rvalid_ch", rvalid, 64'(2'b01 << e.ch));
                check("rsp_latency", 64'(cyc - e.cyc), 64'(LAT));
                check("err", err, e.err);
                if (e.chk) check("rdata", rdata, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 2'b11; we = '0; be = '0; addr = '0; wdata = '0;
        @(negedge clk);
        check("reset_gnt", gnt, 2'b00);
        check("reset_rvalid", rvalid, 2'b00);
        check("reset_rdata", rdata, 32'h0);
        check("reset_err", err, 1'b0);
        req = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;

        // Write, read back, be=0 no-op write, back-to-back write/read, preload words.
        add(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        add(0, 0, 4'hF, 32'h10, 32'h0,        0, 1, 32'hDEADBEEF);
        add(0, 1, 4'h0, 32'h10, 32'hFFFFFFFF, 0, 0, 0);
        add(0, 0, 4'h0, 32'h10, 32'h0,        0, 1, 32'hDEADBEEF);
        add(0, 1, 4'hF, 32'h20, 32'h11223344, 0, 0, 0);
        add(0, 1, 4'h2, 32'h20, 32'hAAAAAAAA, 0, 0, 0);
        add(0, 0, 4'hF, 32'h20, 32'h0,        0, 1, 32'h1122AA44);
        add(0, 1, 4'hF, 32'h30, 32'h13579BDF, 0, 0, 0);
        add(0, 0, 4'hF, 32'h33, 32'h0,        0, 1, 32'h13579BDF);
        add(0, 1, 4'hF, 32'h0,  32'h01234567, 0, 0, 0);
        add(0, 1, 4'hF, 32'h4,  32'h89ABCDEF, 0, 0, 0);
        add(0, 1, 4'hF, 32'h8,  32'h0BADF00D, 0, 0, 0);
        run(40);

        // Out of range on ch1: word 1024 aliases word 0 if the check is missing.
        add(1, 1, 4'hF, 32'h1000, 32'hCAFEF00D, 1, 1, 32'h0);
        add(1, 0, 4'hF, 32'h1000, 32'h0,        1, 1, 32'h0);
        add(1, 0, 4'hF, 32'h0,    32'h0,        0, 1, 32'h01234567);
        run(20);

        // Both channels contend; pointer sits at 0 after the last ch1 grant.
        add(0, 0, 4'hF, 32'h10, 32'h0,        0, 1, 32'hDEADBEEF);
        add(0, 0, 4'hF, 32'h20, 32'h0,        0, 1, 32'h1122AA44);
        add(1, 0, 4'hF, 32'h4,  32'h0,        0, 1, 32'h89ABCDEF);
        add(1, 1, 4'hF, 32'hC,  32'h55667788, 0, 0, 0);
        gseq = '{2'b01, 2'b10, 2'b01, 2'b10};
        run(20);

        // Back-to-back reads: responses on consecutive cycles, in order.
        add(0, 0, 4'hF, 32'h0, 32'h0, 0, 1, 32'h01234567);
        add(0, 0, 4'hF, 32'h4, 32'h0, 0, 1, 32'h89ABCDEF);
        add(0, 0, 4'hF, 32'h8, 32'h0, 0, 1, 32'h0BADF00D);
        run(20);

        // Reset in the cycle after a grant drops the outstanding response.
        req = 2'b10; we = 2'b00; addr = 64'h0000_0004_0000_0000;
        @(negedge clk);
        check("pre_reset_gnt", gnt, 2'b10);
        @(posedge clk); #1;
        rst = 1'b1;
        req = 2'b11;
        @(negedge clk);
        check("midrst_gnt", gnt, 2'b00);
        check("midrst_rvalid", rvalid, 2'b00);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_err", err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        req = 2'b00;
        sb.delete();
        add(0, 0, 4'hF, 32'hC, 32'h0, 0, 1, 32'h55667788);
        add(1, 0, 4'hF, 32'h8, 32'h0, 0, 1, 32'h0BADF00D);
        gseq = '{2'b01, 2'b10};
        run(20);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
